// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU front end.
//   ppu_state_e      : front-end FSM encoding (FILL=0, RUN=1, HOLD=2)
//   CTRL_NOP         : all-zero control bundle used as the pipeline bubble
//   DEFAULT_RESET_PC : default PC after reset
//   DEFAULT_STEP     : default PC increment in bytes
package ppu_pkg;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } ppu_state_e;

    localparam int unsigned DEFAULT_CTRL_W = 22;
    localparam logic [DEFAULT_CTRL_W-1:0] CTRL_NOP = '0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
    localparam int unsigned DEFAULT_STEP     = 4;

endpackage

// File: rtl/ppu_fetch_pipe_if.sv
// Bus bundle between the PPU front end and its surroundings
// (instruction memory, control unit, hazard logic, EX stage).
//   master : the front end (drives fetch address, IF/ID and ID/EX outputs)
//   slave  : the environment (drives imem data, hazards, branch, ctrl_in)
interface ppu_fetch_pipe_if
    import ppu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CTRL_W  = 22,
    parameter int unsigned CNT_W   = 16
) ();

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               annul;
    logic [CTRL_W-1:0]  ctrl_in;
    logic [INSTR_W-1:0] instr_id;
    logic [ADDR_W-1:0]  pc_id;
    logic               valid_id;
    logic [CTRL_W-1:0]  ctrl_ex;
    ppu_state_e         state;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output imem_addr, instr_id, pc_id, valid_id, ctrl_ex, state, bubble_cnt,
        input  imem_data, stall, branch_taken, branch_target, annul, ctrl_in
    );

    modport slave (
        input  imem_addr, instr_id, pc_id, valid_id, ctrl_ex, state, bubble_cnt,
        output imem_data, stall, branch_taken, branch_target, annul, ctrl_in
    );

endinterface

// File: rtl/ppu_pc_unit.sv
// PC/nPC register pair for SPARC-style delayed branching.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   hold_i           : freeze PC and nPC (load-use stall)
//   branch_taken_i   : load nPC from branch_target_i instead of nPC+STEP
//   branch_target_i  : branch destination
//   pc_o             : current fetch PC
module ppu_pc_unit
    import ppu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       STEP     = DEFAULT_STEP
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hold_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] StepW = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] npc_d, npc_q;

    // PC always takes the old nPC, so the delay slot is fetched before the target.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (!hold_i) begin
            pc_d  = npc_q;
            npc_d = branch_taken_i ? branch_target_i : npc_q + StepW;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + StepW;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ppu_fetch_pipe.sv
// PPU front end: PC/nPC unit, IF/ID register, hazard bubble mux, ID/EX
// control register and a saturating bubble counter.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   fetch_bus : imem address/data, hazard and branch inputs, ctrl_in from the
//               control unit; instr_id/pc_id/valid_id, ctrl_ex, state and
//               bubble_cnt outputs
module ppu_fetch_pipe
    import ppu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       CTRL_W   = 22,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       STEP     = DEFAULT_STEP,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    ppu_fetch_pipe_if.master  fetch_bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    ppu_state_e         state_d, state_q;
    logic [ADDR_W-1:0]  pc;
    logic               stall_eff;
    logic [INSTR_W-1:0] instr_id_d, instr_id_q;
    logic [ADDR_W-1:0]  pc_id_d, pc_id_q;
    logic               valid_id_d, valid_id_q;
    logic [CTRL_W-1:0]  ctrl_ex_d, ctrl_ex_q;
    logic [CNT_W-1:0]   bubble_cnt_d, bubble_cnt_q;

    // IF/ID is empty in FILL, so there is nothing a load-use stall could protect.
    assign stall_eff = fetch_bus.stall && (state_q != StFill);

    ppu_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .STEP     (STEP)
    ) u_pc_unit (
        .clk_i           (clk),
        .rst_ni          (reset),
        .hold_i          (stall_eff),
        .branch_taken_i  (fetch_bus.branch_taken),
        .branch_target_i (fetch_bus.branch_target),
        .pc_o            (pc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFill:         state_d = StRun;
            StRun, StHold:  state_d = fetch_bus.stall ? StHold : StRun;
            default:        state_d = StFill;
        endcase
    end

    always_comb begin
        instr_id_d   = instr_id_q;
        pc_id_d      = pc_id_q;
        valid_id_d   = valid_id_q;
        bubble_cnt_d = bubble_cnt_q;

        if (!stall_eff) begin
            instr_id_d = fetch_bus.annul ? '0 : fetch_bus.imem_data;
            pc_id_d    = pc;
            valid_id_d = !fetch_bus.annul;
        end

        // A stalled or empty ID slot must not issue its decode into EX.
        ctrl_ex_d = (fetch_bus.stall || !valid_id_q) ? CTRL_W'(CTRL_NOP) : fetch_bus.ctrl_in;

        if (stall_eff && (bubble_cnt_q != CntMax)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StFill;
            instr_id_q   <= '0;
            pc_id_q      <= '0;
            valid_id_q   <= 1'b0;
            ctrl_ex_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_id_q   <= instr_id_d;
            pc_id_q      <= pc_id_d;
            valid_id_q   <= valid_id_d;
            ctrl_ex_q    <= ctrl_ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_bus.imem_addr  = pc;
    assign fetch_bus.instr_id   = instr_id_q;
    assign fetch_bus.pc_id      = pc_id_q;
    assign fetch_bus.valid_id   = valid_id_q;
    assign fetch_bus.ctrl_ex    = ctrl_ex_q;
    assign fetch_bus.state      = state_q;
    assign fetch_bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ppu_fetch_pipe.sv
// Self-checking bench for ppu_fetch_pipe: directed scenarios with literal
// expectations plus randomized hazards/branches against a behavioural model.
module tb_ppu_fetch_pipe;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CTRL_W  = 22;
    localparam int unsigned STEP    = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the architectural view of the front end.
    logic [31:0]       m_pc, m_npc, m_instr, m_pcid;
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_state;
    int                m_cnt;

    ppu_fetch_pipe_if #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) bus ();

    ppu_fetch_pipe #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (32'h0),
        .STEP     (STEP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bus)
    );

    // Zero-wait instruction memory.
    assign bus.imem_data = 32'hA000_0000 + bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_model();
        expect_eq("imem_addr", bus.imem_addr, m_pc);
        expect_eq("instr_id", bus.instr_id, m_instr);
        expect_eq("pc_id", bus.pc_id, m_pcid);
        expect_eq("valid_id", 32'(bus.valid_id), 32'(m_valid));
        expect_eq("ctrl_ex", 32'(bus.ctrl_ex), 32'(m_ctrl));
        expect_eq("state", 32'(bus.state), 32'(m_state));
        expect_eq("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_npc   = 32'h0 + STEP;
        m_instr = '0;
        m_pcid  = '0;
        m_valid = 1'b0;
        m_ctrl  = '0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    // One clock: predict from the rules, let the DUT clock, compare.
    task automatic step();
        logic [31:0]       n_pc, n_npc, n_instr, n_pcid;
        logic              n_valid;
        logic [CTRL_W-1:0] n_ctrl;
        int                n_state, n_cnt;
        bit                fill, hold;
        fill    = (m_state == 0);
        hold    = bus.stall && !fill;
        n_pc    = m_pc;
        n_npc   = m_npc;
        n_instr = m_instr;
        n_pcid  = m_pcid;
        n_valid = m_valid;
        if (!hold) begin
            n_pc    = m_npc;
            n_npc   = bus.branch_taken ? bus.branch_target : m_npc + STEP;
            n_instr = bus.annul ? 32'h0 : 32'hA000_0000 + m_pc;
            n_pcid  = m_pc;
            n_valid = !bus.annul;
        end
        n_ctrl  = (bus.stall || !m_valid) ? '0 : bus.ctrl_in;
        n_cnt   = (hold && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        n_state = fill ? 1 : (bus.stall ? 2 : 1);
        @(posedge clk);
        #1;
        m_pc = n_pc; m_npc = n_npc; m_instr = n_instr; m_pcid = n_pcid;
        m_valid = n_valid; m_ctrl = n_ctrl; m_state = n_state; m_cnt = n_cnt;
        check_model();
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.annul         = 1'b0;
        bus.ctrl_in       = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        reset = 1'b0;
        #2;
        model_reset();
        expect_eq("rst_imem_addr", bus.imem_addr, 32'h0);
        expect_eq("rst_state", 32'(bus.state), 32'd0);
        expect_eq("rst_valid", 32'(bus.valid_id), 32'd0);
        expect_eq("rst_cnt", 32'(bus.bubble_cnt), 32'd0);
        check_model();
        @(negedge clk);
        reset = 1'b1;

        // Plain fetch: 0,4,8 with instr_id one cycle behind.
        step();
        expect_eq("seq_addr4", bus.imem_addr, 32'h4);
        expect_eq("seq_state_run", 32'(bus.state), 32'd1);
        expect_eq("seq_instr0", bus.instr_id, 32'hA000_0000);
        expect_eq("seq_valid", 32'(bus.valid_id), 32'd1);
        bus.ctrl_in = 22'h12345;
        step();
        expect_eq("seq_addr8", bus.imem_addr, 32'h8);
        expect_eq("seq_ctrl", 32'(bus.ctrl_ex), 32'h12345);
        expect_eq("seq_pcid4", bus.pc_id, 32'h4);

        // Two-cycle load-use stall at PC=8.
        bus.stall = 1'b1;
        step();
        expect_eq("stall_state_hold", 32'(bus.state), 32'd2);
        expect_eq("stall_ctrl_nop", 32'(bus.ctrl_ex), 32'h0);
        step();
        expect_eq("stall_addr_held", bus.imem_addr, 32'h8);
        expect_eq("stall_instr_held", bus.instr_id, 32'hA000_0004);
        expect_eq("stall_cnt2", 32'(bus.bubble_cnt), 32'd2);
        bus.stall = 1'b0;
        step();
        expect_eq("resume_state_run", 32'(bus.state), 32'd1);
        expect_eq("resume_addr12", bus.imem_addr, 32'hC);
        expect_eq("resume_instr8", bus.instr_id, 32'hA000_0008);

        // Stall during FILL is ignored.
        do_reset();
        bus.stall = 1'b1;
        step();
        expect_eq("fill_stall_addr4", bus.imem_addr, 32'h4);
        expect_eq("fill_stall_cnt0", 32'(bus.bubble_cnt), 32'd0);
        bus.stall = 1'b0;

        // Delayed branch at PC=8 to 0x40, delay slot at 12 annulled.
        do_reset();
        step();
        step();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        step();
        expect_eq("br_delay_slot", bus.imem_addr, 32'hC);
        bus.branch_taken = 1'b0; bus.annul = 1'b1;
        step();
        expect_eq("br_target", bus.imem_addr, 32'h40);
        expect_eq("annul_valid0", 32'(bus.valid_id), 32'd0);
        expect_eq("annul_instr0", bus.instr_id, 32'h0);
        bus.annul = 1'b0; bus.ctrl_in = 22'h3FFFFF;
        step();
        expect_eq("br_target_plus", bus.imem_addr, 32'h44);
        expect_eq("annul_ctrl_nop", 32'(bus.ctrl_ex), 32'h0);

        // Branch during stall is ignored; it applies when the stall drops.
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
        step();
        expect_eq("sb_pc_held", bus.imem_addr, 32'h44);
        bus.stall = 1'b0;
        step();
        expect_eq("sb_delay", bus.imem_addr, 32'h48);
        bus.branch_taken = 1'b0;
        step();
        expect_eq("sb_target", bus.imem_addr, 32'h80);

        // Address wrap at the top of the space.
        bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
        step();
        bus.branch_taken = 1'b0;
        step();
        expect_eq("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        expect_eq("wrap_zero", bus.imem_addr, 32'h0);

        // Saturating counter, then reset in the middle of the stall.
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        expect_eq("sat_cnt", 32'(bus.bubble_cnt), 32'd3);
        do_reset();
        expect_eq("midrst_state", 32'(bus.state), 32'd0);
        expect_eq("midrst_cnt", 32'(bus.bubble_cnt), 32'd0);
        expect_eq("midrst_addr", bus.imem_addr, 32'h0);
        idle_inputs();

        // Random hazards, branches and annuls.
        for (int i = 0; i < 600; i++) begin
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.branch_taken  = ($urandom_range(0, 4) == 0);
            bus.branch_target = $urandom() & 32'hFFFF_FFFC;
            bus.annul         = ($urandom_range(0, 6) == 0);
            bus.ctrl_in       = CTRL_W'($urandom());
            if (i % 150 == 75) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
